// File: rtl/branch_trace_driver_pkg.sv
// branch_pkg: definitions shared by the trace driver, its bus interface and
// the predictor under evaluation.
//   state_e  : driver run state (IDLE, RUN, FLUSH, DONE)
//   IP_W_DEF : default instruction-pointer width, equal to the predictor's input_ip
package branch_pkg;

    localparam int IP_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/branch_trace_driver_if.sv
// branch_trace_driver_if: trace-entry handshake plus predictor step bus.
//   trace_valid/ready/ip/taken/last : trace source -> driver
//   pred_step/ip/taken              : driver -> predictor (step = clock enable)
//   pred_prediction                 : predictor -> driver (registered prediction)
// Modports:
//   master : trace source and predictor side (the driver's environment)
//   slave  : branch_trace_driver side
interface branch_trace_driver_if
    import branch_pkg::*;
#(
    parameter int IP_W = IP_W_DEF
) ();
    logic            trace_valid;
    logic            trace_ready;
    logic [IP_W-1:0] trace_ip;
    logic            trace_taken;
    logic            trace_last;
    logic            pred_step;
    logic [IP_W-1:0] pred_ip;
    logic            pred_taken;
    logic            pred_prediction;

    modport master (
        output trace_valid, trace_ip, trace_taken, trace_last, pred_prediction,
        input  trace_ready, pred_step, pred_ip, pred_taken
    );

    modport slave (
        input  trace_valid, trace_ip, trace_taken, trace_last, pred_prediction,
        output trace_ready, pred_step, pred_ip, pred_taken
    );
endinterface

// File: rtl/branch_trace_driver_sat_counter.sv
// sat_counter: CNT_W-bit up counter that holds at all-ones instead of wrapping.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : synchronous clear (wins over inc_i)
//   inc_i      : add one this edge unless already saturated
//   count_o    : current count
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/branch_trace_driver.sv
// branch_trace_driver: replays a recorded branch trace into a predictor and
// scores it.
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle pulse, begins a run from IDLE or DONE
//   bus (slave)       : trace handshake in, predictor step bus out
//   branch_count      : entries scored (saturating)
//   mispredict_count  : entries whose prediction differed from the outcome
//   done              : run complete, counts are final
module branch_trace_driver
    import branch_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int IP_W  = IP_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    branch_trace_driver_if.slave  bus,
    output logic [CNT_W-1:0]      branch_count,
    output logic [CNT_W-1:0]      mispredict_count,
    output logic                  done
);
    state_e          state_q;
    state_e          state_d;
    logic            handshake;
    logic            run_start;
    logic            prev_taken_q;   // outcome of the previous stepped branch
    logic [IP_W-1:0] last_ip_q;      // ip of the previous stepped branch, replayed in FLUSH
    logic            exp_taken_q;    // outcome the prediction of the next cycle is scored against
    logic            cmp_pending_q;  // a step happened last edge; its prediction is visible now
    logic            mispredict;

    assign handshake = (state_q == RUN) && bus.trace_valid;
    assign run_start = start && ((state_q == IDLE) || (state_q == DONE));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (handshake && bus.trace_last) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. FLUSH re-presents the final branch so the predictor can
    // train on its outcome; that step is never scored.
    always_comb begin
        bus.trace_ready = 1'b0;
        bus.pred_step   = 1'b0;
        bus.pred_ip     = '0;
        bus.pred_taken  = 1'b0;
        done            = 1'b0;
        case (state_q)
            RUN: begin
                bus.trace_ready = 1'b1;
                if (handshake) begin
                    bus.pred_step  = 1'b1;
                    bus.pred_ip    = bus.trace_ip;
                    bus.pred_taken = prev_taken_q;
                end
            end
            FLUSH: begin
                bus.pred_step  = 1'b1;
                bus.pred_ip    = last_ip_q;
                bus.pred_taken = prev_taken_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Step bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_taken_q  <= 1'b0;
            last_ip_q     <= '0;
            exp_taken_q   <= 1'b0;
            cmp_pending_q <= 1'b0;
        end else begin
            cmp_pending_q <= handshake;
            if (handshake) begin
                prev_taken_q <= bus.trace_taken;
                last_ip_q    <= bus.trace_ip;
                exp_taken_q  <= bus.trace_taken;
            end else if (run_start) begin
                prev_taken_q <= 1'b0;
            end
        end
    end

    assign mispredict = cmp_pending_q && (bus.pred_prediction != exp_taken_q);

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (run_start),
        .inc_i   (cmp_pending_q),
        .count_o (branch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (run_start),
        .inc_i   (mispredict),
        .count_o (mispredict_count)
    );
endmodule

// File: tb/tb_branch_trace_driver.sv
module tb_branch_trace_driver;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] branch_count, mispredict_count;
    logic [3:0]  branch_count4, mispredict_count4;
    logic        done, done4;

    int total = 0;
    int bad   = 0;

    branch_trace_driver_if #(.IP_W(64)) bus ();
    branch_trace_driver_if #(.IP_W(64)) bus4 ();

    branch_trace_driver #(.CNT_W(32), .IP_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .bus              (bus),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .done             (done)
    );

    // Narrow-counter copy fed the same stimulus to exercise saturation.
    branch_trace_driver #(.CNT_W(4), .IP_W(64)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .bus              (bus4),
        .branch_count     (branch_count4),
        .mispredict_count (mispredict_count4),
        .done             (done4)
    );

    always #5 clk = ~clk;

    // Stub predictor: registered prediction that advances only on pred_step.
    int   mode = 0;
    logic pred_q = 1'b0;

    function automatic logic pf(input int md, input logic [63:0] ip, input logic prev, input logic tk);
        case (md)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ~tk;
            default: return ip[0] ^ prev;
        endcase
    endfunction

    always @(posedge clk)
        if (bus.pred_step) pred_q <= pf(mode, bus.pred_ip, bus.pred_taken, bus.trace_taken);

    assign bus.pred_prediction  = pred_q;
    assign bus4.trace_valid     = bus.trace_valid;
    assign bus4.trace_ip        = bus.trace_ip;
    assign bus4.trace_taken     = bus.trace_taken;
    assign bus4.trace_last      = bus.trace_last;
    assign bus4.pred_prediction = pred_q;

    // Monitor: record every predictor step; flag non-zero pred bus when idle.
    logic [63:0] obs_ip[$];
    logic        obs_tk[$];
    int          idle_bad = 0;

    always @(negedge clk) begin
        if (bus.pred_step) begin
            obs_ip.push_back(bus.pred_ip);
            obs_tk.push_back(bus.pred_taken);
        end else if (bus.pred_ip != 64'd0 || bus.pred_taken) begin
            idle_bad++;
        end
    end

    // Stimulus drive registers
    logic        tv = 1'b0, tk = 1'b0, tl = 1'b0;
    logic [63:0] tip = '0;
    assign bus.trace_valid = tv;
    assign bus.trace_ip    = tip;
    assign bus.trace_taken = tk;
    assign bus.trace_last  = tl;

    // Current trace
    logic [63:0] t_ip[$];
    logic        t_tk[$];

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: mispredictions of a run, from the stub's rule applied to
    // each entry with the previous outcome (0 for the first entry).
    function automatic int model_mis();
        int   m = 0;
        logic prev = 1'b0;
        for (int k = 0; k < t_tk.size(); k++) begin
            if (pf(mode, t_ip[k], prev, t_tk[k]) != t_tk[k]) m++;
            prev = t_tk[k];
        end
        return m;
    endfunction

    function automatic longint sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic run_trace(input int id, input int gap_max, input int exp_b, input int exp_m);
        int   n = t_ip.size();
        int   seq_bad = 0;
        int   waited;
        logic prev = 1'b0;
        obs_ip.delete();
        obs_tk.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clr_branch", branch_count, 0);
        chk("start_clr_mis", mispredict_count, 0);
        chk("run_ready", bus.trace_ready, 1);
        chk("run_done", done, 0);
        for (int k = 0; k < n; k++) begin
            tv = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            tv = 1'b1; tip = t_ip[k]; tk = t_tk[k]; tl = (k == n - 1);
            waited = 0;
            while (!bus.trace_ready && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 8) chk("ready_timeout", waited, 0);
            @(negedge clk);
            tv = 1'b0; tl = 1'b0;
        end
        // Cycle after the last handshake: FLUSH, not yet done.
        chk("flush_step", bus.pred_step, 1);
        chk("flush_done", done, 0);
        @(negedge clk);
        chk("done_t2", done, 1);
        chk("branch_count", branch_count, exp_b);
        chk("mispredict_count", mispredict_count, exp_m);
        chk("branch_count4", branch_count4, sat4(exp_b));
        chk("mispredict_count4", mispredict_count4, sat4(exp_m));
        chk("step_count", obs_ip.size(), n + 1);
        for (int k = 0; k <= n && k < obs_ip.size(); k++) begin
            if (k < n) begin
                if (obs_ip[k] != t_ip[k] || obs_tk[k] != prev) seq_bad++;
                prev = t_tk[k];
            end else if (obs_ip[k] != t_ip[n-1] || obs_tk[k] != t_tk[n-1]) begin
                seq_bad++;
            end
        end
        chk("step_sequence", seq_bad, 0);
        chk("idle_pred_bus", idle_bad, 0);
        $display("run %0d mode=%0d n=%0d branches=%0d mispredicts=%0d steps=%0d",
                 id, mode, n, branch_count, mispredict_count, obs_ip.size());
    endtask

    typedef struct {
        int          md;
        int          n;
        int          gap_max;
        logic [31:0] taken_bits;
        int          exp_b;
        int          exp_m;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 4,  0, 32'h0000_000F, 4,  4};
        vecs[1] = '{1, 4,  0, 32'h0000_0005, 4,  2};   // outcomes 1,0,1,0
        vecs[2] = '{1, 4,  3, 32'h0000_0005, 4,  2};
        vecs[3] = '{2, 20, 0, 32'h000A_5A5F, 20, 20};
        vecs[4] = '{0, 3,  0, 32'h0000_0007, 3,  3};
        vecs[5] = '{0, 3,  0, 32'h0000_0002, 3,  1};   // restart from DONE

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.trace_ready, 0);
        chk("rst_step", bus.pred_step, 0);
        chk("rst_pred_ip", bus.pred_ip, 0);
        chk("rst_pred_taken", bus.pred_taken, 0);
        chk("rst_done", done, 0);
        chk("rst_branch", branch_count, 0);
        chk("rst_mis", mispredict_count, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            mode = vecs[v].md;
            t_ip.delete(); t_tk.delete();
            for (int k = 0; k < vecs[v].n; k++) begin
                t_ip.push_back(64'h0000_4000 + 64'(k * 4));
                t_tk.push_back(vecs[v].taken_bits[k]);
            end
            run_trace(v, vecs[v].gap_max, vecs[v].exp_b, vecs[v].exp_m);
        end

        // Reset after the 2nd of 5 handshakes.
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tv = 1'b1; tip = 64'h8000 + 64'(k); tk = 1'b1; tl = 1'b0;
            @(negedge clk);
        end
        chk("pre_reset_branch", branch_count, 1);
        tip = 64'h8002;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_ready", bus.trace_ready, 0);
        chk("mid_reset_step", bus.pred_step, 0);
        chk("mid_reset_branch", branch_count, 0);
        chk("mid_reset_mis", mispredict_count, 0);
        chk("mid_reset_done", done, 0);
        begin
            int steps = 0;
            repeat (3) begin
                @(negedge clk);
                if (bus.pred_step) steps++;
            end
            chk("post_reset_no_step", steps, 0);
        end
        tv = 1'b0;
        $display("run reset_mid_run branches=%0d ready=%0d", branch_count, bus.trace_ready);

        // start and reset together: reset wins, stays IDLE.
        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("start_reset_ready", bus.trace_ready, 0);
        @(negedge clk);
        chk("start_reset_idle", bus.trace_ready, 0);
        $display("run start_with_reset ready=%0d", bus.trace_ready);

        // Randomized runs against the reference model.
        for (int r = 0; r < 10; r++) begin
            int n;
            mode = int'($urandom_range(3, 0));
            n = int'($urandom_range(12, 1));
            t_ip.delete(); t_tk.delete();
            for (int k = 0; k < n; k++) begin
                t_ip.push_back({$urandom, $urandom});
                t_tk.push_back(1'($urandom));
            end
            run_trace(100 + r, 2, n, model_mis());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
